dynamic_lighting_seq: RTL and testbench

//  Parametrised successor to the Ex4 dynamic LED block: steps an RGB colour code through a legal

---
 rtl/dynamic_lighting_pkg.sv | 79 +++++++
 rtl/lighting_prescaler.sv | 33 +++
 rtl/dynamic_lighting_seq.sv | 75 +++++++
 tb/tb_dynamic_lighting_seq.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/dynamic_lighting_pkg.sv
// rtl/dynamic_lighting_pkg.sv - mode/dir encodings and the shared next-code function
package dynamic_lighting_pkg;

  localparam logic [1:0] MODE_UP       = 2'b00;
  localparam logic [1:0] MODE_DOWN     = 2'b01;
  localparam logic [1:0] MODE_PINGPONG = 2'b10;
  localparam logic [1:0] MODE_HOLD     = 2'b11;

  localparam logic [0:0] DIR_UP   = 1'b0;
  localparam logic [0:0] DIR_DOWN = 1'b1;

  typedef struct packed {
    logic [31:0] code;
    logic        dir;
    logic        wrap;
  } next_t;

  // Endpoint compares come before +/-1, so in-range codes never overflow.
  // An out-of-range code recovers to lo heading up, flagged as a wrap.
  function automatic next_t next_code(input logic [1:0]  mode,
                                      input logic        dir,
                                      input logic [31:0] cur,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
    next_t r;
    r.code = cur;
    r.dir  = dir;
    r.wrap = 1'b0;
    if (cur < lo || cur > hi) begin
      r.code = lo;
      r.dir  = DIR_UP;
      r.wrap = 1'b1;
    end else begin
      case (mode)
        MODE_UP: begin
          r.dir = DIR_UP;
          if (cur == hi) begin
            r.code = lo;
            r.wrap = 1'b1;
          end else begin
            r.code = cur + 32'd1;
          end
        end
        MODE_DOWN: begin
          r.dir = DIR_DOWN;
          if (cur == lo) begin
            r.code = hi;
            r.wrap = 1'b1;
          end else begin
            r.code = cur - 32'd1;
          end
        end
        MODE_PINGPONG: begin
          if (dir == DIR_UP) begin
            if (cur == hi) begin
              r.code = hi - 32'd1;
              r.dir  = DIR_DOWN;
              r.wrap = 1'b1;
            end else begin
              r.code = cur + 32'd1;
            end
          end else begin
            if (cur == lo) begin
              r.code = lo + 32'd1;
              r.dir  = DIR_UP;
              r.wrap = 1'b1;
            end else begin
              r.code = cur - 32'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/lighting_prescaler.sv
// rtl/lighting_prescaler.sv - step-rate divider, one tick every DIV enabled cycles
module lighting_prescaler
  import dynamic_lighting_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  // With DIV=1 the count never leaves 0, so tick simply follows en.
  assign tick = en & (count == LAST);

  // Count enabled cycles; restart on a tick or while cleared, freeze otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr || tick) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/dynamic_lighting_seq.sv
// rtl/dynamic_lighting_seq.sv - colour sequencer: prescaled up/down/ping-pong stepping with strobes
module dynamic_lighting_seq
  import dynamic_lighting_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int MIN_CODE = 1,
  parameter int MAX_CODE = 6,
  parameter int DIV      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             button,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] colour,
  output logic             step,
  output logic             wrap
);

  if (MIN_CODE < 0 || MIN_CODE >= MAX_CODE || MAX_CODE > (2 ** WIDTH) - 1 || DIV < 1)
  begin : g_param_check
    $error("dynamic_lighting_seq: illegal MIN_CODE/MAX_CODE/WIDTH/DIV");
  end

  localparam logic [WIDTH-1:0] MIN_C = WIDTH'(MIN_CODE);

  logic [WIDTH-1:0] colour_r;
  logic [WIDTH-1:0] cur_code;
  logic             dir_r;
  logic             en;
  logic             clr;
  logic             tick;
  next_t            nxt;
  logic             unused_code_hi;

  // HOLD both blocks stepping and restarts the prescaler; button only freezes it.
  assign en  = button & (mode != MODE_HOLD);
  assign clr = (mode == MODE_HOLD);

  lighting_prescaler #(.DIV(DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (clr),
    .tick (tick)
  );

  assign cur_code = colour_r;
  assign colour   = colour_r;

  assign nxt = next_code(mode, dir_r, 32'(cur_code), 32'(MIN_CODE), 32'(MAX_CODE));
  assign unused_code_hi = |nxt.code[31:WIDTH];

  // Colour and ping-pong direction advance only on step edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      colour_r <= MIN_C;
      dir_r    <= DIR_UP;
    end else if (tick) begin
      colour_r <= nxt.code[WIDTH-1:0];
      dir_r    <= nxt.dir;
    end
  end

  // Strobes are one cycle wide, aligned with the new colour value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step <= 1'b0;
      wrap <= 1'b0;
    end else begin
      step <= tick;
      wrap <= tick & nxt.wrap;
    end
  end

endmodule

// File: tb/tb_dynamic_lighting_seq.sv
// tb/tb_dynamic_lighting_seq.sv - directed self-checking bench for dynamic_lighting_seq
module tb_dynamic_lighting_seq;
  import dynamic_lighting_pkg::*;

  logic       clk;
  logic       rst;
  logic       button;
  logic [1:0] mode;

  logic [2:0] c1, c3, cp;
  logic       s1, s3, sp;
  logic       w1, w3, wp;

  int n_checks;
  int n_fail;

  int up_seq [12] = '{2, 3, 4, 5, 6, 1, 2, 3, 4, 5, 6, 1};
  int dn_seq [4]  = '{6, 5, 4, 3};
  int pp_seq [12] = '{2, 3, 4, 5, 6, 5, 4, 3, 2, 1, 2, 3};

  dynamic_lighting_seq #(.WIDTH(3), .MIN_CODE(1), .MAX_CODE(6), .DIV(1)) d1 (
    .clk(clk), .rst(rst), .button(button), .mode(mode),
    .colour(c1), .step(s1), .wrap(w1)
  );

  dynamic_lighting_seq #(.WIDTH(3), .MIN_CODE(1), .MAX_CODE(6), .DIV(3)) d3 (
    .clk(clk), .rst(rst), .button(button), .mode(mode),
    .colour(c3), .step(s3), .wrap(w3)
  );

  dynamic_lighting_seq #(.WIDTH(3), .MIN_CODE(2), .MAX_CODE(3), .DIV(1)) dp (
    .clk(clk), .rst(rst), .button(button), .mode(mode),
    .colour(cp), .step(sp), .wrap(wp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic [1:0] m);
    rst    = 1'b0;
    button = 1'b1;
    mode   = m;
    cyc(1);
    rst = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    button   = 1'b1;
    mode     = MODE_UP;

    // Reset held with button high
    cyc(5);
    check("rst_colour1", 32'(c1), 1);
    check("rst_step1",   32'(s1), 0);
    check("rst_wrap1",   32'(w1), 0);
    check("rst_colour3", 32'(c3), 1);
    check("rst_colourp", 32'(cp), 2);
    rst = 1'b1;

    // UP, DIV=1
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      check("up_colour", 32'(c1), up_seq[i]);
      check("up_step",   32'(s1), 1);
      check("up_wrap",   32'(w1), (up_seq[i] == 1) ? 1 : 0);
    end

    // DOWN, DIV=3
    do_reset(MODE_DOWN);
    for (int i = 1; i <= 12; i++) begin
      cyc(1);
      check("dn_colour", 32'(c3), (i < 3) ? 1 : dn_seq[i / 3 - 1]);
      check("dn_step",   32'(s3), (i % 3 == 0) ? 1 : 0);
      check("dn_wrap",   32'(w3), (i == 3) ? 1 : 0);
    end

    // PINGPONG, DIV=1, plus two-code range
    do_reset(MODE_PINGPONG);
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      check("pp_colour",  32'(c1), pp_seq[i]);
      check("pp_wrap",    32'(w1), (i == 5 || i == 10) ? 1 : 0);
      check("pp2_colour", 32'(cp), (i % 2 == 1) ? 2 : 3);
      if (i >= 1) check("pp2_wrap", 32'(wp), 1);
    end

    // Button hold and HOLD mode, DIV=3
    do_reset(MODE_UP);
    cyc(2);
    check("bh_pre_colour", 32'(c3), 1);
    check("bh_pre_step",   32'(s3), 0);
    button = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      check("bh_frozen_colour", 32'(c3), 1);
      check("bh_frozen_step",   32'(s3), 0);
    end
    button = 1'b1;
    cyc(1);
    check("bh_resume_colour", 32'(c3), 2);
    check("bh_resume_step",   32'(s3), 1);
    mode = MODE_HOLD;
    cyc(4);
    check("hold_colour", 32'(c3), 2);
    check("hold_step",   32'(s3), 0);
    mode = MODE_UP;
    cyc(2);
    check("hold_exit_colour", 32'(c3), 2);
    check("hold_exit_step",   32'(s3), 0);
    cyc(1);
    check("hold_first_colour", 32'(c3), 3);
    check("hold_first_step",   32'(s3), 1);

    // Mode switch one cycle before a step edge
    cyc(3);
    check("ms_at4", 32'(c3), 4);
    cyc(2);
    check("ms_pre_colour", 32'(c3), 4);
    mode = MODE_DOWN;
    cyc(1);
    check("ms_colour", 32'(c3), 3);
    check("ms_step",   32'(s3), 1);
    check("ms_wrap",   32'(w3), 0);

    // Illegal code recovery
    mode = MODE_UP;
    force d1.cur_code = 3'd7;
    cyc(1);
    release d1.cur_code;
    check("seu_colour", 32'(c1), 1);
    check("seu_wrap",   32'(w1), 1);
    check("seu_step",   32'(s1), 1);
    cyc(1);
    check("seu_next_colour", 32'(c1), 2);
    check("seu_next_wrap",   32'(w1), 0);

    // Asynchronous reset mid-cycle
    cyc(1);
    check("ar_pre_colour", 32'(c1), 3);
    #3;
    rst = 1'b0;
    #1;
    check("ar_colour1", 32'(c1), 1);
    check("ar_step1",   32'(s1), 0);
    check("ar_wrap1",   32'(w1), 0);
    check("ar_colour3", 32'(c3), 1);
    cyc(1);
    rst = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
